// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types, line levels and frame-size helper for the arbitrated UART transmitter.
// Build option: UART_TX_ARBITER_PARITY_EN adds a parity bit after the data bits.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_TX_ARBITER_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    // Number of bit periods in one frame: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned data_w,
                                               input int unsigned stop_bits);
        return 1 + data_w + PARITY_BITS + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake bundle shared by all transmit sources.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotating priority pointer, combinational pick.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant_onehot,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        found        = 1'b0;
        cand         = '0;
        grant_onehot = '0;
        grant_idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % N);
            if (!found && req[cand]) begin
                found              = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

    // Pointer moves to one past the winner whenever a grant is taken.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (32'(grant_idx) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + IDX_W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit line between N_REQ byte sources.
// Build option: UART_TX_ARBITER_PARITY_EN adds parity_odd and a parity bit.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BRR_W     = 16,
    parameter int unsigned STOP_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [BRR_W-1:0]         brr,
`ifdef UART_TX_ARBITER_PARITY_EN
    input  logic                     parity_odd,
`endif
    uart_tx_arbiter_if.slave         req_if,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     done,
    output logic                     tx_out
);
    localparam int unsigned ID_W       = $clog2(N_REQ);
    localparam int unsigned FRAME_BITS = frame_bits(DATA_W, STOP_BITS);
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);

    tx_state_e          state_q,    state_d;
    logic [DATA_W-1:0]  shift_q,    shift_d;
    logic [BRR_W-1:0]   brr_q,      brr_d;
    logic [BRR_W-1:0]   baud_q,     baud_d;
    logic [BIT_W-1:0]   bit_q,      bit_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               tx_q,       tx_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
`ifdef UART_TX_ARBITER_PARITY_EN
    logic               par_q,      par_d;
`endif

    logic [N_REQ-1:0]   arb_onehot;
    logic [ID_W-1:0]    arb_idx;
    logic [DATA_W-1:0]  sel_byte;
    logic               grant_fire;
    logic               bit_end;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_if.req_valid),
        .advance      (grant_fire),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx)
    );

    // Grant only from IDLE; held off while reset is asserted.
    assign grant_fire       = rst_n && (state_q == IDLE) && enable && (|req_if.req_valid);
    assign req_if.req_ready = arb_onehot & {N_REQ{grant_fire}};
    assign sel_byte         = req_if.req_data[32'(arb_idx) * DATA_W +: DATA_W];
    assign bit_end          = (baud_q == brr_q);

    // Frame sequencer and next-cycle output values.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        brr_d      = brr_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        grant_id_d = grant_id_q;
`ifdef UART_TX_ARBITER_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    shift_d    = sel_byte;
                    brr_d      = brr;
                    baud_d     = '0;
                    bit_d      = '0;
                    grant_id_d = arb_idx;
`ifdef UART_TX_ARBITER_PARITY_EN
                    par_d      = (^sel_byte) ^ parity_odd;
`endif
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BRR_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d   = '0;
`ifdef UART_TX_ARBITER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BRR_W'(1);
                end
            end
`ifdef UART_TX_ARBITER_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BRR_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BRR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the next state.
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_ARBITER_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            STOP:    tx_d = STOP_BIT;
            default: tx_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (bit_d == BIT_W'(STOP_BITS - 1)) && (baud_d == brr_d);
    end

    // State and output registers; reset drops the line to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            brr_q      <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            grant_id_q <= '0;
            tx_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_ARBITER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            brr_q      <= brr_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            grant_id_q <= grant_id_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_ARBITER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_out   = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected frames queued at stimulus, checked on the line.
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BRR_W     = 16;
    localparam int unsigned STOP_BITS = 2;
`ifdef UART_TX_ARBITER_PARITY_EN
    localparam int unsigned PAR_BITS  = 1;
`else
    localparam int unsigned PAR_BITS  = 0;
`endif

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    enable;
    logic [BRR_W-1:0]        brr;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [1:0]              grant_id;
    logic                    busy;
    logic                    done;
    logic                    tx_out;
`ifdef UART_TX_ARBITER_PARITY_EN
    logic                    parity_odd;
`endif

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) req_if ();
    assign req_if.req_valid = req_valid;
    assign req_if.req_data  = req_data;

    uart_tx_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .BRR_W     (BRR_W),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .brr        (brr),
`ifdef UART_TX_ARBITER_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .req_if     (req_if),
        .grant_id   (grant_id),
        .busy       (busy),
        .done       (done),
        .tx_out     (tx_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int id, input logic [7:0] d, input logic odd);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.par  = (^d) ^ odd;
        return e;
    endfunction

    // Wait for the next grant, then check every cycle of the frame against the popped entry.
    task automatic rx_frame(input int brr_v, input bit drop, output int waited);
        exp_t        e;
        logic [15:0] bits;
        int          len;
        int          bi;
        bit          ok;
        waited = 0;
        ok     = 1'b0;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e    = sb_q.pop_front();
        len  = (1 + DATA_W + PAR_BITS + STOP_BITS) * (brr_v + 1);
        bits = '1;
        bits[0] = 1'b0;
        for (int j = 0; j < DATA_W; j++) bits[1 + j] = e.data[j];
        if (PAR_BITS == 1) bits[1 + DATA_W] = e.par;
        while (waited < 300) begin
            @(negedge clk);
            waited++;
            if (req_if.req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            check("wait_tx_idle", 32'(tx_out), 32'd1);
        end
        if (!ok) begin
            check("grant_timeout", 32'd0, 32'd1);
            return;
        end
        check("ready_onehot", 32'(req_if.req_ready), 32'd1 << e.id);
        check("grant_tx_idle", 32'(tx_out), 32'd1);
        check("grant_busy", 32'(busy), 32'd0);
        if (drop) begin
            @(posedge clk);
            #1;
            req_valid[e.id] = 1'b0;
        end
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            bi = (k - 1) / (brr_v + 1);
            check("tx_bit", 32'(tx_out), 32'(bits[bi]));
            check("busy", 32'(busy), 32'd1);
            check("done", 32'(done), 32'(k == len));
            if (k == 1) check("grant_id", 32'(grant_id), 32'(e.id));
            if (req_if.req_ready != '0) check("ready_in_frame", 32'(req_if.req_ready), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n     = 1'b0;
        enable    = 1'b1;
        brr       = '0;
        req_valid = '1;
        req_data  = '0;
`ifdef UART_TX_ARBITER_PARITY_EN
        parity_odd = 1'b0;
`endif
        // Reset state, with requests pending to show no handshake during reset.
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(req_if.req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;

        // Single requester, byte A5, four cycles per bit; valid dropped after accept.
        @(posedge clk); #1;
        brr           = 16'd3;
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        sb_q.push_back(mk(0, 8'hA5, 1'b0));
        rx_frame(3, 1'b1, w);
        @(negedge clk);
        check("post_frame_busy", 32'(busy), 32'd0);
        check("post_frame_tx", 32'(tx_out), 32'd1);

        // Round-robin from a fresh pointer, all requesters valid, one cycle per bit.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        brr       = 16'd0;
        req_data  = {8'h81, 8'h5A, 8'hC3, 8'h3C};
        req_valid = 4'b1111;
        sb_q.push_back(mk(0, 8'h3C, 1'b0));
        sb_q.push_back(mk(1, 8'hC3, 1'b0));
        sb_q.push_back(mk(2, 8'h5A, 1'b0));
        sb_q.push_back(mk(3, 8'h81, 1'b0));
        sb_q.push_back(mk(0, 8'h3C, 1'b0));
        for (int f = 0; f < 5; f++) begin
            rx_frame(0, 1'b0, w);
            if (f > 0) check("rr_gap", 32'(w), 32'd1);
        end
        req_valid = '0;

        // brr change and enable drop during DATA: frame keeps its timing, no grant while disabled.
        @(posedge clk); #1;
        brr            = 16'd3;
        req_data[15:8] = 8'h96;
        req_valid      = 4'b0010;
        sb_q.push_back(mk(1, 8'h96, 1'b0));
        fork
            rx_frame(3, 1'b1, w);
            begin
                int t;
                t = 0;
                while (t < 300 && req_if.req_ready == '0) begin
                    @(negedge clk);
                    t++;
                end
                repeat (8) @(posedge clk);
                #1;
                brr             = 16'd7;
                enable          = 1'b0;
                req_data[23:16] = 8'h0F;
                req_valid[2]    = 1'b1;
            end
        join
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("disabled_ready", 32'(req_if.req_ready), 32'd0);
            check("disabled_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        enable = 1'b1;
        sb_q.push_back(mk(2, 8'h0F, 1'b0));
        rx_frame(7, 1'b1, w);
        check("resume_latency", 32'(w), 32'd1);

        // Reset during DATA bit 3 returns the line high immediately and clears the pointer.
        @(posedge clk); #1;
        brr             = 16'd1;
        req_data[31:24] = 8'h00;
        req_valid       = 4'b1000;
        w = 0;
        while (w < 300 && req_if.req_ready == '0) begin
            @(negedge clk);
            w++;
        end
        check("rst_case_grant", 32'(req_if.req_ready), 32'b1000);
        repeat (9) @(posedge clk);
        #1;
        check("pre_rst_tx", 32'(tx_out), 32'd0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("mid_rst_tx", 32'(tx_out), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_grant_id", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        brr             = 16'd0;
        req_data[7:0]   = 8'h5A;
        req_data[23:16] = 8'h21;
        req_valid       = 4'b0101;
        sb_q.push_back(mk(0, 8'h5A, 1'b0));
        sb_q.push_back(mk(2, 8'h21, 1'b0));
        rx_frame(0, 1'b1, w);
        rx_frame(0, 1'b1, w);
        check("after_rst_gap", 32'(w), 32'd1);

`ifdef UART_TX_ARBITER_PARITY_EN
        // Parity bit for 07: even parity sends 1, odd parity sends 0.
        @(posedge clk); #1;
        parity_odd    = 1'b0;
        req_data[7:0] = 8'h07;
        req_valid     = 4'b0001;
        sb_q.push_back(mk(0, 8'h07, 1'b0));
        rx_frame(0, 1'b1, w);
        @(posedge clk); #1;
        parity_odd = 1'b1;
        req_valid  = 4'b0001;
        sb_q.push_back(mk(0, 8'h07, 1'b1));
        rx_frame(0, 1'b1, w);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one serial transmit line between N_REQ byte requesters.
- Round-robin arbiter picks a requester, latches its byte, then sequences the frame: 1 start bit, DATA_W data bits LSB-first, STOP_BITS stop bits.
- Bit timing comes from a programmable baud divisor (brr).
- Sits between the core-side transmit sources and the serial pin.

Parameters:
- N_REQ, 4, number of requesters (≥2)
- DATA_W, 8, data bits per frame
- BRR_W, 16, baud divisor width
- STOP_BITS, 2, stop bits per frame (1 or 2)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  permits new grants
- brr  input  BRR_W  bit period minus one, in clk cycles
- req_valid  input  N_REQ  per-requester byte pending
- req_data  input  N_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
- req_ready  output  N_REQ  one-hot accept pulse
- grant_id  output  $clog2(N_REQ)  index of the current/last granted requester
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame end
- tx_out  output  1  serial line, idle high

Behaviour:
- Reset (async, rst_n=0):
  - tx_out=1; busy=0; done=0; req_ready=0; grant_id=0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
  - Baud and bit counters=0; FSM=IDLE.
  - Reset mid-frame aborts the frame immediately; tx_out returns high in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
- IDLE, grant rule:
  - Grant occurs in cycle T when enable=1 and |req_valid.
  - Winner = first valid index searching upward from (last grant+1) mod N_REQ.
  - req_ready[winner]=1 for cycle T only. Handshake completes on valid&ready.
  - In cycle T: byte and brr latched into internal registers; grant_id updated; FSM → START.
- Timing:
  - Every bit is held brr_q+1 cycles. brr=0 gives one cycle per bit.
  - brr changes mid-frame are ignored.
- START: tx_out=0 from T+1 for one bit period, then → DATA.
- DATA: tx_out=shift[0]; shift right each bit period; after DATA_W bits → STOP (or PARITY with the optional feature).
- STOP: tx_out=1 for STOP_BITS bit periods.
  - done=1 in the final cycle of the last stop bit; FSM → IDLE.
  - The earliest next grant is the cycle after done. Back-to-back frames therefore have exactly one idle cycle with tx_out=1.
- busy=1 from T+1 through the done cycle inclusive.
- Total frame length = (1+DATA_W+STOP_BITS)*(brr_q+1) cycles from T+1 through done.
- Boundary cases:
  - req_valid dropping during a frame has no effect; the byte is already latched.
  - enable=0 mid-frame: the current frame completes; no new grant while enable=0.
  - Only the pointed-to requester valid: it is granted. A single requester valid repeatedly is granted every frame.
  - Simultaneous done and new req_valid: the grant waits one cycle, per the IDLE rule above.
- Counter rule: the baud counter counts 0..brr_q, then wraps and advances the bit counter. No overflow is possible because the counter is BRR_W wide.

Optional Feature:
- Macro: UART_TX_ARBITER_PARITY_EN.
- With the macro defined:
  - Adds input parity_odd (1 bit), latched at grant.
  - Adds a PARITY state between DATA and STOP. It sends one bit: even parity = ^data, odd parity = ~^data.
  - Frame length becomes (2+DATA_W+STOP_BITS)*(brr_q+1).
- Without the macro: no parity_odd port and no PARITY state; frame format as above.

Decomposition:
- Package uart_tx_arbiter_pkg:
  - State enum typedef (IDLE, START, DATA, PARITY, STOP).
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
  - Function for the frame bit count.
- Sub-module rr_arbiter:
  - Parameter N.
  - Ports: clk, rst_n, req, advance.
  - Outputs: grant_onehot, grant_idx.
  - Holds the rotating pointer; reused by other shared-resource blocks.

Test Plan:
- Single requester (N_REQ=4, brr=3, req_valid=4'b0001, data=8'hA5):
  - req_ready[0] pulses at T; tx_out = 0,1,0,1,0,0,1,0,1,1,1, each held 4 cycles.
  - done at T+44; busy high for T+1..T+44.
- Round-robin: all four valid continuously, brr=0 → grant order 0,1,2,3,0; consecutive grants 12 cycles apart; one idle-high cycle between frames.
- Mid-frame changes: brr changed 3→7 and enable dropped during DATA → frame keeps 4-cycle bits and completes; no grant while enable=0; grant resumes 1 cycle after enable=1.
- Reset mid-frame: rst_n low during DATA bit 3 → tx_out=1, busy=0 in the same cycle. After release, requesters 2 and 0 valid → requester 0 granted first (pointer reset).
- Parity (UART_TX_ARBITER_PARITY_EN defined, data=8'h07, brr=0):
  - parity_odd=0 → parity bit 1; parity_odd=1 → 0.
  - done at T+12.
